// File: rtl/slavefifo2b_stream_out_rd.sv
// Stream-OUT read controller for the FX3 32-bit Slave FIFO, 2-bit address mode.
// Ports: clk_100/reset_; rd_mode_selected, check_en, flagc_d, flagd_d, data_in in;
//        slrd_rd_, sloe_rd_, rd_data, rd_data_valid, pkt_done, burst_words, err_count out.
module slavefifo2b_stream_out_rd #(
    parameter int RD_LATENCY = 2,
    parameter int TAIL_WORDS = 3,
    parameter int CNT_W      = 16
) (
    input  logic             clk_100,
    input  logic             reset_,
    input  logic             rd_mode_selected,
    input  logic             check_en,
    input  logic             flagc_d,
    input  logic             flagd_d,
    input  logic [31:0]      data_in,
    output logic             slrd_rd_,
    output logic             sloe_rd_,
    output logic [31:0]      rd_data,
    output logic             rd_data_valid,
    output logic             pkt_done,
    output logic [CNT_W-1:0] burst_words,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_READ  = 3'd2,
        S_TAIL  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    localparam logic [2:0] TW = 3'(TAIL_WORDS);

    state_t                r_state;
    logic [2:0]            r_tail;
    logic [RD_LATENCY-1:0] r_pipe;
    logic                  r_oe_d;
    logic [CNT_W-1:0]      r_live;
    logic [31:0]           r_exp;

    logic w_oe;
    logic w_rd;

    // SLOE# leads SLRD# by a cycle: a read is only issued once OE was
    // already asserted in the previous cycle.
    assign w_oe = (r_state == S_READ) || (r_state == S_TAIL) ||
                  (r_state == S_DRAIN);
    assign w_rd = r_oe_d &&
                  (((r_state == S_READ) && flagd_d) ||
                   ((r_state == S_TAIL) && (r_tail != 3'd0)));

    assign slrd_rd_ = ~w_rd;
    assign sloe_rd_ = ~w_oe;

    always_ff @(posedge clk_100 or negedge reset_) begin
        if (!reset_) begin
            r_state       <= S_IDLE;
            r_tail        <= 3'd0;
            r_pipe        <= '0;
            r_oe_d        <= 1'b0;
            r_live        <= '0;
            r_exp         <= 32'd0;
            rd_data       <= 32'd0;
            rd_data_valid <= 1'b0;
            pkt_done      <= 1'b0;
            burst_words   <= '0;
            err_count     <= '0;
        end else begin
            r_oe_d        <= w_oe;
            r_pipe        <= {r_pipe[RD_LATENCY-2:0], w_rd};
            rd_data_valid <= r_pipe[RD_LATENCY-1];
            if (r_pipe[RD_LATENCY-1])
                rd_data <= data_in;
            pkt_done <= 1'b0;

            if (rd_data_valid)
                r_live <= r_live + CNT_W'(1);

            // Expected value resyncs to the received word on every capture.
            if (!rd_mode_selected) begin
                r_exp     <= 32'd0;
                err_count <= '0;
            end else if (rd_data_valid) begin
                if (check_en && (rd_data != r_exp) &&
                    (err_count != {CNT_W{1'b1}}))
                    err_count <= err_count + CNT_W'(1);
                r_exp <= rd_data + 32'd1;
            end

            case (r_state)
                S_IDLE: begin
                    if (rd_mode_selected)
                        r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (!rd_mode_selected) begin
                        r_state <= S_IDLE;
                    end else if (flagc_d) begin
                        if (flagd_d) begin
                            r_state <= S_READ;
                        end else begin
                            r_tail  <= TW;
                            r_state <= (TW == 3'd0) ? S_DRAIN : S_TAIL;
                        end
                    end
                end
                S_READ: begin
                    if (!rd_mode_selected) begin
                        r_state <= S_DRAIN;
                    end else if (!flagd_d) begin
                        r_tail  <= TW;
                        r_state <= (TW == 3'd0) ? S_DRAIN : S_TAIL;
                    end
                end
                S_TAIL: begin
                    if (w_rd)
                        r_tail <= r_tail - 3'd1;
                    if (!rd_mode_selected || (r_tail == 3'd0) ||
                        ((r_tail == 3'd1) && w_rd))
                        r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    // Leave only once the last captured word has been counted.
                    if ((r_pipe == '0) && !rd_data_valid) begin
                        pkt_done    <= 1'b1;
                        burst_words <= r_live;
                        r_live      <= '0;
                        r_state     <= rd_mode_selected ? S_WAIT : S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_slavefifo2b_stream_out_rd.sv
// Bench for slavefifo2b_stream_out_rd: FX3 read-side model feeding a
// scoreboard of issued words, plus a pattern/error reference model.
module tb_slavefifo2b_stream_out_rd;

    localparam int L  = 2;
    localparam int TW = 3;
    localparam int CW = 16;

    logic          clk_100 = 1'b0;
    logic          reset_  = 1'b0;
    logic          mode    = 1'b0;
    logic          check_en = 1'b1;
    logic          flagc   = 1'b0;
    logic          flagd   = 1'b0;
    logic [31:0]   data_in = 32'd0;
    logic          slrd_rd_;
    logic          sloe_rd_;
    logic [31:0]   rd_data;
    logic          rd_data_valid;
    logic          pkt_done;
    logic [CW-1:0] burst_words;
    logic [CW-1:0] err_count;

    slavefifo2b_stream_out_rd #(
        .RD_LATENCY(L), .TAIL_WORDS(TW), .CNT_W(CW)
    ) dut (
        .clk_100(clk_100),
        .reset_(reset_),
        .rd_mode_selected(mode),
        .check_en(check_en),
        .flagc_d(flagc),
        .flagd_d(flagd),
        .data_in(data_in),
        .slrd_rd_(slrd_rd_),
        .sloe_rd_(sloe_rd_),
        .rd_data(rd_data),
        .rd_data_valid(rd_data_valid),
        .pkt_done(pkt_done),
        .burst_words(burst_words),
        .err_count(err_count)
    );

    always #5 clk_100 = ~clk_100;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // FX3 model: a read seen at an edge puts the next word on the bus
    // L edges later; the same word is queued as the expected capture.
    int          n_rd = 0;
    int          n_oe = 0;
    int          rd_mark = 0;
    int          inj_idx = -1;
    logic [31:0] inj_val = 32'd0;
    logic [31:0] wbase = 32'd0;
    logic [31:0] sbq[$];
    logic        sh_v[L+1];
    logic [31:0] sh_w[L+1];

    always @(negedge clk_100) begin : fx3
        logic [31:0] w;
        if (!reset_) begin
            sbq.delete();
            for (int i = 0; i <= L; i++) begin
                sh_v[i] = 1'b0;
                sh_w[i] = 32'd0;
            end
            data_in = 32'd0;
        end else begin
            for (int i = L; i > 0; i--) begin
                sh_v[i] = sh_v[i-1];
                sh_w[i] = sh_w[i-1];
            end
            sh_v[0] = 1'b0;
            sh_w[0] = 32'd0;
            if (!sloe_rd_) n_oe++;
            if (!slrd_rd_) begin
                w = wbase + 32'(n_rd - rd_mark);
                if ((n_rd - rd_mark) == inj_idx) w = inj_val;
                sh_v[0] = 1'b1;
                sh_w[0] = w;
                sbq.push_back(w);
                n_rd++;
            end
            data_in = sh_v[L] ? sh_w[L] : $urandom();
        end
    end

    // Monitor: pops the scoreboard on every valid word and keeps the
    // word-count / mismatch reference for each completed burst.
    int          n_pop = 0;
    int          n_pkt = 0;
    logic [31:0] m_exp = 32'd0;
    logic [15:0] m_err = 16'd0;
    logic [15:0] m_cnt = 16'd0;

    always @(negedge clk_100) begin : mon
        logic [31:0] e;
        if (!reset_) begin
            m_exp = 32'd0;
            m_err = 16'd0;
            m_cnt = 16'd0;
        end else begin
            if (pkt_done) begin
                n_pkt++;
                chk("pkt_burst_words", burst_words, m_cnt);
                chk("pkt_err_count", err_count, m_err);
                m_cnt = 16'd0;
            end
            if (rd_data_valid) begin
                if (sbq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL rd_data: unexpected word %0h", rd_data);
                end else begin
                    e = sbq.pop_front();
                    chk("rd_data", rd_data, e);
                end
                n_pop++;
                m_cnt++;
            end
            if (!mode) begin
                m_exp = 32'd0;
                m_err = 16'd0;
            end else if (rd_data_valid) begin
                if (check_en && (rd_data != m_exp) && (m_err != 16'hFFFF))
                    m_err++;
                m_exp = rd_data + 32'd1;
            end
        end
    end

    task automatic tick();
        @(posedge clk_100);
        #1;
    endtask

    task automatic timeout(input string nm);
        tests++;
        fails++;
        $display("FAIL %s: timeout", nm);
    endtask

    // len = reads while flagd_d is high; flagd_d then falls (TW tail reads).
    task automatic burst(input int len, input bit keep, input int exp_err);
        int mark, pop0, pk, lim;
        bit done;
        mark = n_rd; pop0 = n_pop; pk = n_pkt; rd_mark = n_rd;
        lim = (len == 0) ? 1 : len;
        mode = 1'b1; flagc = 1'b1; flagd = (len != 0);
        done = 1'b0;
        for (int c = 0; c < len + 200 && !done; c++) begin
            tick();
            if (n_rd - mark >= lim) begin
                flagd = 1'b0;
                flagc = 1'b0;
            end
            if (n_pkt != pk) done = 1'b1;
        end
        if (!done) timeout("burst_pkt_done");
        chk("burst_reads", 64'(n_rd - mark), 64'(len + TW));
        chk("burst_words_seen", 64'(n_pop - pop0), 64'(len + TW));
        chk("burst_words_out", burst_words, 16'(len + TW));
        if (exp_err >= 0) chk("burst_err_count", err_count, 64'(exp_err));
        if (!keep) begin
            mode = 1'b0;
            tick();
            tick();
        end
    endtask

    task automatic mode_drop_test();
        int mark, pop0, pk;
        bit done;
        mark = n_rd; pop0 = n_pop; pk = n_pkt; rd_mark = n_rd;
        wbase = 32'd0; inj_idx = -1; check_en = 1'b1;
        mode = 1'b1; flagc = 1'b1; flagd = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            tick();
            if (n_rd - mark == 3) done = 1'b1;
        end
        if (!done) timeout("mode_drop_reads");
        mode = 1'b0;
        tick();
        chk("drop_slrd_high", slrd_rd_, 1'b1);
        done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            tick();
            if (n_pkt != pk) done = 1'b1;
        end
        if (!done) timeout("mode_drop_pkt");
        chk("drop_reads", 64'(n_rd - mark), 64'd4);
        chk("drop_words_seen", 64'(n_pop - pop0), 64'd4);
        chk("drop_burst_words", burst_words, 16'd4);
        flagc = 1'b0; flagd = 1'b0;
        tick();
        tick();
        chk("drop_sloe_idle", sloe_rd_, 1'b1);
        chk("drop_err_cleared", err_count, 16'd0);
    endtask

    task automatic reset_test();
        int mark;
        bit done;
        mark = n_rd; rd_mark = n_rd; wbase = 32'd0; inj_idx = -1;
        mode = 1'b1; flagc = 1'b1; flagd = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            tick();
            if (n_rd - mark >= 1) done = 1'b1;
        end
        if (!done) timeout("reset_tail_reads");
        #2 reset_ = 1'b0;
        #1;
        chk("rst_slrd", slrd_rd_, 1'b1);
        chk("rst_sloe", sloe_rd_, 1'b1);
        chk("rst_valid", rd_data_valid, 1'b0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_burst_words", burst_words, 16'd0);
        chk("rst_err_count", err_count, 16'd0);
        mode = 1'b0; flagc = 1'b0;
        tick();
        tick();
        reset_ = 1'b1;
        tick();
    endtask

    initial begin
        int len, oe0;
        bit keep;
        repeat (3) @(posedge clk_100);
        #1;
        chk("reset_slrd", slrd_rd_, 1'b1);
        chk("reset_sloe", sloe_rd_, 1'b1);
        chk("reset_valid", rd_data_valid, 1'b0);
        chk("reset_rd_data", rd_data, 32'd0);
        chk("reset_pkt_done", pkt_done, 1'b0);
        chk("reset_burst_words", burst_words, 16'd0);
        chk("reset_err_count", err_count, 16'd0);
        reset_ = 1'b1;
        tick();

        wbase = 32'd0; inj_idx = -1; check_en = 1'b1;
        burst(8, 1'b0, 0);

        inj_idx = 5; inj_val = 32'h55;
        burst(8, 1'b0, 2);

        inj_idx = -1;
        oe0 = n_oe;
        burst(0, 1'b0, 0);
        chk("short_sloe_cycles", 64'(n_oe - oe0 >= TW + L + 1), 64'd1);

        inj_idx = 0; inj_val = 32'h77;
        burst(2, 1'b1, 2);
        mode_drop_test();

        reset_test();
        wbase = 32'd0; inj_idx = -1; check_en = 1'b1;
        burst(8, 1'b0, 0);

        check_en = 1'b0; wbase = 32'hFFFF_FFFE;
        burst(32'h10002 - TW, 1'b1, 0);
        check_en = 1'b1; wbase = 32'h0001_0000;
        burst(2, 1'b0, 0);

        for (int t = 0; t < 8; t++) begin
            len = $urandom_range(0, 20);
            keep = 1'($urandom_range(0, 1));
            check_en = 1'($urandom_range(0, 1));
            wbase = $urandom_range(0, 1) ? 32'd0 : $urandom();
            inj_idx = $urandom_range(0, 1) ? $urandom_range(0, len + TW - 1) : -1;
            inj_val = $urandom();
            burst(len, keep, -1);
        end

        mode = 1'b0;
        tick();
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
